dual_port_mem: RTL
==================

Name: dual_port_mem

Overview:
Parametrised instruction/data memory model for the pipelined CPU bench, replacing the fixed single-port word memory.
- Provides an instruction read port and a data read/write port, each with a valid/ready request and a response valid.
- Adds byte write strobes, configurable read latency, misalignment flagging and a shared-bank mode with arbitration.
- Sits beside the core in the bench; contents are loaded by file into the internal array `mem`.

Parameters:
ADDR_W, 32, byte-address width of both ports
DATA_W, 32, word width; multiple of 8
DEPTH, 1024, number of words; power of two
RD_LAT, 1, request-to-response latency in cycles; legal 1..4
DUAL_PORT, 1, 1 = independent ports; 0 = single shared bank with arbitration

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
i_req_valid  in  1  instruction read request
i_req_ready  out  1  instruction request accepted this cycle
i_addr  in  ADDR_W  instruction byte address
i_rsp_valid  out  1  instruction response valid
i_rdata  out  DATA_W  instruction read data
d_req_valid  in  1  data request
d_req_ready  out  1  data request accepted this cycle
d_wen  in  1  1 = write, 0 = read
d_wstrb  in  DATA_W/8  byte write enables; bit k covers byte k
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  write data
d_rsp_valid  out  1  data response valid (reads and write acks)
d_rdata  out  DATA_W  data read data; 0 on write ack
d_err  out  1  response flags misaligned request; qualified by d_rsp_valid

Behaviour:
- Reset (rst low, async): all rsp_valid, rdata and d_err outputs go to 0; latency pipelines are flushed. Array `mem` is not cleared.
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Acceptance: a request is accepted on the rising edge where valid && ready.
- DUAL_PORT=1: both ready outputs are tied to 1.
- DUAL_PORT=0: data port has priority. d_req_ready=1; i_req_ready = !d_req_valid.
- Reads: data is sampled at the accept edge. After exactly RD_LAT edges, rsp_valid=1 and rdata are held for 1 cycle. Back-to-back requests give back-to-back responses, in order.
- Writes: bytes with d_wstrb[k]=1 are written at the accept edge. A d_rsp_valid ack follows RD_LAT edges later with d_rdata=0.
- Same-edge I read and D write to the same word (DUAL_PORT=1): the I read returns the old data (read-before-write).
- Read issued after a write to the same word: returns the new data.
- Misaligned request (addr[1:0]!=0):
  - Data port: accepted; no write; response has d_err=1, d_rdata=0.
  - Instruction port: i_rdata=0 (no error port).
- d_wstrb=0 on a write: no array change; normal ack.
- Reset asserted mid-operation:
  - In-flight responses are discarded, with no rsp_valid after reset release.
  - Writes committed before reset assertion persist.
- Between responses, rsp_valid=0 and rdata hold the last value. Only the valid flag is meaningful.

Decomposition:
- Package mem_pkg holds: RD_LAT_MIN=1, RD_LAT_MAX=4, function strb_w(DATA_W)=DATA_W/8, response struct {valid, data, err}.
- Sub-module rsp_pipe (parameters RD_LAT, DATA_W) is an RD_LAT-stage valid/data/err delay line with async active-low flush. It is instantiated once per port.

Test Plan:
- RD_LAT=1, DUAL_PORT=1: write 0xDEADBEEF to addr 0x10 with wstrb=4'hF, then read 0x10 -> ack one cycle later; read response 0xDEADBEEF one cycle after the read accept.
- Write wstrb=4'b0010, data 0x0000AB00 over 0xDEADBEEF at 0x10; read back -> 0xDEADABEF.
- Same edge: I reads 0x10 while D writes 0x12345678 to 0x10 -> i_rdata=0xDEADABEF. A following D read returns 0x12345678.
- DUAL_PORT=0: hold d_req_valid=1 for 3 cycles with i_req_valid=1 -> i_req_ready=0 for those 3 cycles. I is accepted on the 4th cycle; its response arrives RD_LAT later.
- RD_LAT=3: four back-to-back I reads of 0x0,0x4,0x8,0xC -> i_rsp_valid high on 4 consecutive cycles starting 3 edges after the first accept, data in order. Address 0x1000 with DEPTH=1024 returns the word at 0x0.
- D read of 0x13 -> d_rsp_valid=1, d_err=1, d_rdata=0. Pull rst low with 2 responses in flight -> no rsp_valid after release; earlier writes still readable.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_pkg
// Brief   : Shared constants, helpers and response type for dual_port_mem.
// Rev     : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    // Widest word the response type can carry.
    localparam int MAX_DATA_W = 256;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [MAX_DATA_W-1:0] data;
        logic                  err;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module : rsp_pipe
// Brief  : RD_LAT-stage valid/data/err delay line with async active-low flush.
// Rev    : 1.0 - initial release
// ============================================================================
module rsp_pipe
    import mem_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_err,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err
);

    localparam int c_LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    rsp_t r_stage [c_LAT];
    rsp_t w_in;
    logic w_unused_pad;

    always_comb begin
        w_in                   = '0;
        w_in.valid             = i_valid;
        w_in.data[DATA_W-1:0]  = i_data;
        w_in.err               = i_err;
    end

    // Payload only moves with a valid beat, so the output data holds between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < c_LAT; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0].valid <= w_in.valid;
            if (w_in.valid) begin
                r_stage[0].data <= w_in.data;
                r_stage[0].err  <= w_in.err;
            end
            for (int k = 1; k < c_LAT; k++) begin
                r_stage[k].valid <= r_stage[k-1].valid;
                if (r_stage[k-1].valid) begin
                    r_stage[k].data <= r_stage[k-1].data;
                    r_stage[k].err  <= r_stage[k-1].err;
                end
            end
        end
    end

    assign o_valid      = r_stage[c_LAT-1].valid;
    assign o_data       = r_stage[c_LAT-1].data[DATA_W-1:0];
    assign o_err        = r_stage[c_LAT-1].err;
    assign w_unused_pad = ^r_stage[c_LAT-1].data;

endmodule
`default_nettype wire

// File: rtl/dual_port_mem.sv
`default_nettype none
// ============================================================================
// Module : dual_port_mem
// Brief  : Instruction/data memory model with byte strobes, fixed read latency
//          and optional shared-bank arbitration (data port wins).
// Rev    : 1.0 - initial release
// ============================================================================
module dual_port_mem
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 1,
    parameter int DUAL_PORT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req_valid,
    output logic                      i_req_ready,
    input  logic [ADDR_W-1:0]         i_addr,
    output logic                      i_rsp_valid,
    output logic [DATA_W-1:0]         i_rdata,
    input  logic                      d_req_valid,
    output logic                      d_req_ready,
    input  logic                      d_wen,
    input  logic [strb_w(DATA_W)-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]         d_addr,
    input  logic [DATA_W-1:0]         d_wdata,
    output logic                      d_rsp_valid,
    output logic [DATA_W-1:0]         d_rdata,
    output logic                      d_err
);

    localparam int c_IDX_W  = $clog2(DEPTH);
    localparam int c_STRB_W = strb_w(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [c_IDX_W-1:0] w_i_idx;
    logic [c_IDX_W-1:0] w_d_idx;
    logic               w_i_mis;
    logic               w_d_mis;
    logic               w_i_acc;
    logic               w_d_acc;
    logic               w_d_wr;
    logic [DATA_W-1:0]  w_i_rd;
    logic [DATA_W-1:0]  w_d_rd;
    logic               w_unused_i_err;
    logic               w_unused_addr;

    generate
        if (DUAL_PORT != 0) begin : g_dual
            assign i_req_ready = 1'b1;
            assign d_req_ready = 1'b1;
        end else begin : g_shared
            assign d_req_ready = 1'b1;
            assign i_req_ready = !d_req_valid;
        end
    endgenerate

    // Upper address bits are dropped so accesses wrap modulo DEPTH words.
    assign w_i_idx       = i_addr[c_IDX_W+1:2];
    assign w_d_idx       = d_addr[c_IDX_W+1:2];
    assign w_i_mis       = |i_addr[1:0];
    assign w_d_mis       = |d_addr[1:0];
    assign w_unused_addr = ^{i_addr[ADDR_W-1:c_IDX_W+2], d_addr[ADDR_W-1:c_IDX_W+2]};

    assign w_i_acc = i_req_valid && i_req_ready;
    assign w_d_acc = d_req_valid && d_req_ready;
    assign w_d_wr  = w_d_acc && d_wen && !w_d_mis;

    // Reads see the array before this edge's write, giving read-before-write.
    assign w_i_rd = w_i_mis ? '0 : mem[w_i_idx];
    assign w_d_rd = (w_d_mis || d_wen) ? '0 : mem[w_d_idx];

    always_ff @(posedge clk) begin
        if (w_d_wr) begin
            for (int k = 0; k < c_STRB_W; k++) begin
                if (d_wstrb[k]) begin
                    mem[w_d_idx][8*k +: 8] <= d_wdata[8*k +: 8];
                end
            end
        end
    end

    rsp_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_i_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_i_acc),
        .i_data  (w_i_rd),
        .i_err   (1'b0),
        .o_valid (i_rsp_valid),
        .o_data  (i_rdata),
        .o_err   (w_unused_i_err)
    );

    rsp_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_d_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_d_acc),
        .i_data  (w_d_rd),
        .i_err   (w_d_mis),
        .o_valid (d_rsp_valid),
        .o_data  (d_rdata),
        .o_err   (d_err)
    );

endmodule
`default_nettype wire
